axis_pixel_packer: RTL and testbench

- Upstream feeder for the frame-fetch AXI-Stream slave.
- Accepts a raster pixel stream (one pixel/cycle, valid/ready, start-of-frame flag) and packs 32 consecutive row pixels into one 256-bit pixel-group beat.
- Emits AXI4-Stream with tlast on the final beat of each frame.
- Rotates tdest round-robin across IP_AMT image processors, one frame per processor.

---
 rtl/axis_pkg.sv | 24 ++
 rtl/axis_out_reg.sv | 49 ++++
 rtl/axis_pixel_packer.sv | 166 ++++++++++++++++
 tb/tb_axis_pixel_packer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared pixel-group layout, frame geometry and packer FSM states.
// Also consumed by the frame-fetch cell controller.
package axis_pkg;

    localparam int PIX_W        = 8;
    localparam int PG_PIX       = 32;
    localparam int AXIS_TDATA_W = PIX_W * PG_PIX;

    localparam int FRAME_W      = 320;
    localparam int FRAME_H      = 240;
    localparam int FRAME_PGNUM  = FRAME_W * FRAME_H / PG_PIX;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PACK,
        ST_HOLD
    } pk_state_e;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register: loads a beat when free and holds
// data/last/dest stable while the downstream stalls.
module axis_out_reg #(
    parameter int DATA_W = 256,
    parameter int DEST_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic [DEST_W-1:0] i_dest,
    input  logic              i_tready,
    output logic              o_free,
    output logic              o_tvalid,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tlast,
    output logic [DEST_W-1:0] o_tdest
);

    logic              r_tvalid;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tlast;
    logic [DEST_W-1:0] r_tdest;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tdest  <= '0;
        end else if (i_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= i_data;
            r_tlast  <= i_last;
            r_tdest  <= i_dest;
        end else if (i_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    // A beat may load on the same edge the current one hands off.
    assign o_free   = !r_tvalid || i_tready;
    assign o_tvalid = r_tvalid;
    assign o_tdata  = r_tdata;
    assign o_tlast  = r_tlast;
    assign o_tdest  = r_tdest;

endmodule

// File: rtl/axis_pixel_packer.sv
// Packs a raster pixel stream into PG_PIX-pixel AXI-Stream beats, tlast per
// frame, with tdest rotating round-robin across IP_AMT image processors.
module axis_pixel_packer #(
    parameter int PIX_W        = axis_pkg::PIX_W,
    parameter int PG_PIX       = axis_pkg::PG_PIX,
    parameter int AXIS_TDATA_W = PIX_W * PG_PIX,
    parameter int AXIS_TKEEP_W = AXIS_TDATA_W / 8,
    parameter int FRAME_W      = axis_pkg::FRAME_W,
    parameter int FRAME_H      = axis_pkg::FRAME_H,
    parameter int FRAME_PGNUM  = FRAME_W * FRAME_H / PG_PIX,
    parameter int IP_AMT       = 1,
    parameter int AXIS_TID_W   = 2,
    parameter int AXIS_TID_VAL = 0,
    parameter int AXIS_TDEST_W = (IP_AMT > 1) ? $clog2(IP_AMT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PIX_W-1:0]        pix_data_i,
    input  logic                    pix_sof_i,
    input  logic                    pix_valid_i,
    output logic                    pix_ready_o,
    output logic [AXIS_TID_W-1:0]   m_tid_o,
    output logic [AXIS_TDEST_W-1:0] m_tdest_o,
    output logic [AXIS_TDATA_W-1:0] m_tdata_o,
    output logic [AXIS_TKEEP_W-1:0] m_tkeep_o,
    output logic [AXIS_TKEEP_W-1:0] m_tstrb_o,
    output logic                    m_tlast_o,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i,
    output logic                    frame_done_o,
    output logic                    sof_err_o
);

    import axis_pkg::pk_state_e;
    import axis_pkg::ST_IDLE;
    import axis_pkg::ST_PACK;
    import axis_pkg::ST_HOLD;
    import axis_pkg::clog2_min1;

    localparam int PC_W = clog2_min1(PG_PIX);
    localparam int BC_W = clog2_min1(FRAME_PGNUM);
    localparam logic [PC_W-1:0]         PC_LAST  = PC_W'(PG_PIX - 1);
    localparam logic [BC_W-1:0]         BC_LAST  = BC_W'(FRAME_PGNUM - 1);
    localparam logic [AXIS_TDEST_W-1:0] IDX_LAST = AXIS_TDEST_W'(IP_AMT - 1);

    pk_state_e r_state, w_nxt_state;

    logic [PG_PIX-1:0][PIX_W-1:0] r_acc;
    logic [PG_PIX-1:0][PIX_W-1:0] w_group;
    logic [PC_W-1:0]              r_pix_cnt;
    logic [BC_W-1:0]              r_beat_cnt;
    logic [AXIS_TDEST_W-1:0]      r_frame_idx;
    logic                         r_sof_err;

    logic w_ready, w_acc, w_free, w_pix_last, w_beat_last;
    logic w_load, w_pix_we, w_restart, w_sof_err;

    assign w_ready     = !rst && (r_state != ST_HOLD);
    assign w_acc       = pix_valid_i && w_ready;
    assign w_pix_last  = (r_pix_cnt == PC_LAST);
    assign w_beat_last = (r_beat_cnt == BC_LAST);

    // In PACK the closing pixel bypasses the accumulator; in HOLD it is full.
    assign w_group = (r_state == ST_HOLD) ? r_acc : {pix_data_i, r_acc[PG_PIX-2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        w_pix_we    = 1'b0;
        w_restart   = 1'b0;
        w_sof_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc && pix_sof_i) begin
                    w_restart   = 1'b1;
                    w_nxt_state = ST_PACK;
                end
            end
            ST_PACK: begin
                if (w_acc) begin
                    if (pix_sof_i && (r_pix_cnt != '0 || r_beat_cnt != '0)) begin
                        w_restart = 1'b1;
                        w_sof_err = 1'b1;
                    end else begin
                        w_pix_we = 1'b1;
                        if (w_pix_last) begin
                            if (w_free) begin
                                w_load = 1'b1;
                                if (w_beat_last) w_nxt_state = ST_IDLE;
                            end else begin
                                w_nxt_state = ST_HOLD;
                            end
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (w_free) begin
                    w_load      = 1'b1;
                    w_nxt_state = w_beat_last ? ST_IDLE : ST_PACK;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_pix_cnt   <= '0;
            r_beat_cnt  <= '0;
            r_frame_idx <= '0;
            r_sof_err   <= 1'b0;
        end else begin
            r_sof_err <= w_sof_err;
            // A restart abandons the partial group; stale slots get overwritten.
            if (w_restart) begin
                r_acc[0]   <= pix_data_i;
                r_pix_cnt  <= PC_W'(1);
                r_beat_cnt <= '0;
            end else if (w_pix_we) begin
                r_acc[r_pix_cnt] <= pix_data_i;
                r_pix_cnt        <= w_pix_last ? '0 : r_pix_cnt + PC_W'(1);
            end
            if (w_load) begin
                if (w_beat_last) begin
                    r_beat_cnt  <= '0;
                    r_frame_idx <= (r_frame_idx == IDX_LAST) ? '0 : r_frame_idx + AXIS_TDEST_W'(1);
                end else begin
                    r_beat_cnt <= r_beat_cnt + BC_W'(1);
                end
            end
        end
    end

    axis_out_reg #(
        .DATA_W (AXIS_TDATA_W),
        .DEST_W (AXIS_TDEST_W)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_data   (w_group),
        .i_last   (w_beat_last),
        .i_dest   (r_frame_idx),
        .i_tready (m_tready_i),
        .o_free   (w_free),
        .o_tvalid (m_tvalid_o),
        .o_tdata  (m_tdata_o),
        .o_tlast  (m_tlast_o),
        .o_tdest  (m_tdest_o)
    );

    assign pix_ready_o  = w_ready;
    assign m_tid_o      = AXIS_TID_W'(AXIS_TID_VAL);
    assign m_tkeep_o    = '1;
    assign m_tstrb_o    = '1;
    assign frame_done_o = m_tvalid_o && m_tready_i && m_tlast_o;
    assign sof_err_o    = r_sof_err;

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Directed bench for axis_pixel_packer: 64x2 frames (4 beats), two processors,
// expected beats queued at stimulus time and compared at each handshake.
module tb_axis_pixel_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   pix_data_i = '0;
    logic         pix_sof_i = 1'b0;
    logic         pix_valid_i = 1'b0;
    logic         m_tready_i = 1'b0;
    logic         pix_ready_o;
    logic [1:0]   m_tid_o;
    logic [0:0]   m_tdest_o;
    logic [255:0] m_tdata_o;
    logic [31:0]  m_tkeep_o;
    logic [31:0]  m_tstrb_o;
    logic         m_tlast_o;
    logic         m_tvalid_o;
    logic         frame_done_o;
    logic         sof_err_o;

    axis_pixel_packer #(
        .FRAME_W (64),
        .FRAME_H (2),
        .IP_AMT  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_data_i   (pix_data_i),
        .pix_sof_i    (pix_sof_i),
        .pix_valid_i  (pix_valid_i),
        .pix_ready_o  (pix_ready_o),
        .m_tid_o      (m_tid_o),
        .m_tdest_o    (m_tdest_o),
        .m_tdata_o    (m_tdata_o),
        .m_tkeep_o    (m_tkeep_o),
        .m_tstrb_o    (m_tstrb_o),
        .m_tlast_o    (m_tlast_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tready_i   (m_tready_i),
        .frame_done_o (frame_done_o),
        .sof_err_o    (sof_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic         last;
        logic [0:0]   dest;
    } beat_t;

    beat_t sb[$];
    int checks = 0, errors = 0;
    int fd_cnt = 0, se_cnt = 0, nbeats = 0, cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_beat(input int off, input int b);
        logic [255:0] d;
        d = '0;
        for (int k = 0; k < 32; k++) d[k*8 +: 8] = 8'((off + b*32 + k) & 255);
        return d;
    endfunction

    task automatic push_beat(input int off, input int b, input logic last, input int dest);
        beat_t e;
        e.data = mk_beat(off, b);
        e.last = last;
        e.dest = 1'(dest);
        sb.push_back(e);
    endtask

    task automatic push_frame(input int off, input int dest);
        for (int b = 0; b < 4; b++) push_beat(off, b, b == 3, dest);
    endtask

    // Drive one pixel and return on the negedge after it has been accepted.
    task automatic send(input int d, input logic sof);
        int n;
        pix_data_i  = 8'(d & 255);
        pix_sof_i   = sof;
        pix_valid_i = 1'b1;
        n = 0;
        while (!pix_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("pix_ready_timeout", pix_ready_o, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        pix_valid_i = 1'b0;
        pix_sof_i   = 1'b0;
    endtask

    task automatic send_frame(input int off, input int npix);
        for (int i = 0; i < npix; i++) send(off + i, i == 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    // Output monitor: compare held beats every cycle, pop on handshake.
    always begin
        beat_t e;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (frame_done_o) fd_cnt++;
            if (sof_err_o) se_cnt++;
            if (m_tvalid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", m_tvalid_o, 0);
                end else begin
                    e = sb[0];
                    chk("tdata", m_tdata_o, e.data);
                    chk("tlast", m_tlast_o, e.last);
                    chk("tdest", m_tdest_o, e.dest);
                    if (m_tready_i) begin
                        chk("frame_done", frame_done_o, e.last);
                        void'(sb.pop_front());
                        nbeats++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $error("FAIL global_timeout: observed time %0t expected finish", $time);
        $fatal(1);
    end

    initial begin
        int t0;
        #1 rst = 1'b1;
        #3;
        chk("rst_tvalid", m_tvalid_o, 0);
        chk("rst_tdata", m_tdata_o, 0);
        chk("rst_tlast", m_tlast_o, 0);
        chk("rst_tdest", m_tdest_o, 0);
        chk("rst_frame_done", frame_done_o, 0);
        chk("rst_sof_err", sof_err_o, 0);
        chk("rst_pix_ready", pix_ready_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_pix_ready", pix_ready_o, 1);
        chk("tid", m_tid_o, 0);
        chk("tkeep", m_tkeep_o, 32'hFFFF_FFFF);
        chk("tstrb", m_tstrb_o, 32'hFFFF_FFFF);

        // Garbage before any SOF is discarded.
        for (int i = 0; i < 10; i++) send(200 + i, 1'b0);
        idle();
        repeat (5) @(negedge clk);
        chk("garbage_no_beats", nbeats, 0);

        // Frame A: index values, dest 0, no bubbles, 1-cycle load latency.
        m_tready_i = 1'b1;
        push_frame(0, 0);
        t0 = cyc;
        for (int i = 0; i < 128; i++) begin
            send(i, i == 0);
            if (i == 30) chk("latency_pre", m_tvalid_o, 0);
            if (i == 31) chk("latency_post", m_tvalid_o, 1);
        end
        chk("throughput_cycles", cyc - t0, 128);
        idle();
        drain();
        chk("frame_done_A", fd_cnt, 1);

        // Frames B and C: tdest rotates 1 then wraps to 0.
        push_frame(8'h80, 1);
        send_frame(8'h80, 128);
        idle();
        drain();
        push_frame(8'h40, 0);
        send_frame(8'h40, 128);
        idle();
        drain();
        chk("frame_done_C", fd_cnt, 3);

        // Backpressure: beat0 stalls, accumulator fills, input stalls.
        m_tready_i = 1'b0;
        push_frame(0, 1);
        for (int i = 0; i < 64; i++) send(i, i == 0);
        idle();
        chk("bp_pix_ready", pix_ready_o, 0);
        chk("bp_tvalid", m_tvalid_o, 1);
        repeat (6) @(negedge clk);
        chk("bp_hold_tdata", m_tdata_o, mk_beat(0, 0));
        m_tready_i = 1'b1;
        for (int i = 64; i < 128; i++) send(i, 1'b0);
        idle();
        drain();
        chk("frame_done_bp", fd_cnt, 4);

        // SOF at pixel 40: beat0 already out, frame restarts with same dest.
        push_beat(8'hA0, 0, 1'b0, 0);
        for (int i = 0; i < 40; i++) send(8'hA0 + i, i == 0);
        push_frame(8'h10, 0);
        send_frame(8'h10, 128);
        idle();
        drain();
        chk("sof_err_count", se_cnt, 1);
        chk("frame_done_sof", fd_cnt, 5);

        // Async reset while a beat is held in the output register.
        m_tready_i = 1'b0;
        push_beat(8'h55, 0, 1'b0, 1);
        for (int i = 0; i < 32; i++) send(8'h55 + i, i == 0);
        idle();
        chk("pre_rst_tvalid", m_tvalid_o, 1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_tvalid", m_tvalid_o, 0);
        chk("async_rst_tdata", m_tdata_o, 0);
        chk("async_rst_pix_ready", pix_ready_o, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        m_tready_i = 1'b1;
        #1;
        chk("post_rst_pix_ready", pix_ready_o, 1);

        // Back in IDLE: non-SOF pixels dropped, next frame goes to dest 0.
        for (int i = 0; i < 5; i++) send(i, 1'b0);
        push_frame(8'h33, 0);
        send_frame(8'h33, 128);
        idle();
        drain();
        chk("frame_done_final", fd_cnt, 6);
        chk("sof_err_final", se_cnt, 1);
        chk("beats_total", nbeats, 25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
